// File: rtl/multicycle_core_if.sv
// Switch-input and display-output handshake bundle for multicycle_core.
// The master side is the core. The slave side is the board I/O or testbench.
interface multicycle_core_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] sw_data;
  logic              sw_valid;
  logic              sw_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  sw_data, sw_valid, out_ready,
    output sw_ready, out_data, out_valid
  );

  modport slave (
    output sw_data, sw_valid, out_ready,
    input  sw_ready, out_data, out_valid
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle FETCH/DECODE/EXEC/WB core with a handshaked switch input and display output.
// The optional retired-instruction counter port instret is enabled by defining MCCORE_PERF_CNT_EN.
module multicycle_core #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  multicycle_core_if.master io,
  output logic              halted,
  output logic [PC_W-1:0]   pc
`ifdef MCCORE_PERF_CNT_EN
  ,
  output logic [31:0]       instret
`endif
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_WB,
    S_HALT
  } state_t;

  state_t            state;
  logic [31:0]       instr;
  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] sw_word;
  logic              flag;

  logic              f_j;
  logic              f_b;
  logic              f_we;
  logic [1:0]        f_ws;
  logic [3:0]        f_op;
  logic [4:0]        f_a3;
  logic [7:0]        f_c;
  logic [DATA_W-1:0] se;
  logic [PC_W-1:0]   pc_off;

  logic [DATA_W-1:0] alu_y;
  logic              alu_f;
  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] wb_data;

  assign f_j    = instr[31];
  assign f_b    = instr[30];
  assign f_we   = instr[29];
  assign f_ws   = instr[28:27];
  assign f_op   = instr[26:23];
  assign f_a3   = instr[12:8];
  assign f_c    = instr[7:0];
  assign se     = DATA_W'($signed(f_c));
  assign pc_off = PC_W'($signed(f_c));

  assign imem_addr = pc;

  always_comb begin
    alu_y = '0;
    alu_f = 1'b0;
    sh    = rd2[SH_W-1:0];
    case (f_op)
      4'h0: alu_y = rd1 + rd2;
      4'h1: alu_y = rd1 - rd2;
      4'h2: alu_y = rd1 & rd2;
      4'h3: alu_y = rd1 | rd2;
      4'h4: alu_y = rd1 ^ rd2;
      4'h5: alu_y = rd1 << sh;
      4'h6: alu_y = rd1 >> sh;
      4'h7: alu_y = DATA_W'($signed(rd1) >>> sh);
      4'h8: alu_f = (rd1 == rd2);
      4'h9: alu_f = (rd1 != rd2);
      4'hA: alu_f = ($signed(rd1) < $signed(rd2));
      4'hB: alu_f = ($signed(rd1) >= $signed(rd2));
      4'hC: alu_f = (rd1 < rd2);
      4'hD: alu_f = (rd1 >= rd2);
      default: ;
    endcase
    // Every op with bit 3 set is a compare (or reserved, which has flag 0), so its result is the flag.
    if (f_op[3]) begin
      alu_y = DATA_W'(alu_f);
    end
  end

  always_comb begin
    case (f_ws)
      2'b00:   wb_data = se;
      2'b01:   wb_data = sw_word;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_FETCH;
      pc           <= '0;
      instr        <= '0;
      rd1          <= '0;
      rd2          <= '0;
      alu_res      <= '0;
      sw_word      <= '0;
      flag         <= 1'b0;
      halted       <= 1'b0;
      io.sw_ready  <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
`ifdef MCCORE_PERF_CNT_EN
      instret      <= '0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          // r0 is never written, so reading it from the array always returns 0.
          instr <= imem_rdata;
          rd1   <= regs[imem_rdata[22:18]];
          rd2   <= regs[imem_rdata[17:13]];
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_res <= alu_y;
          flag    <= alu_f;
          if (f_j && (f_c == 8'h00)) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (f_ws == 2'b01) begin
            io.sw_ready <= 1'b1;
            state       <= S_WAIT_IN;
          end else if (f_ws == 2'b11) begin
            io.out_valid <= 1'b1;
            io.out_data  <= rd1;
            state        <= S_WAIT_OUT;
          end else begin
            state <= S_WB;
          end
        end
        S_WAIT_IN: begin
          if (io.sw_valid) begin
            sw_word     <= io.sw_data;
            io.sw_ready <= 1'b0;
            state       <= S_WB;
          end
        end
        S_WAIT_OUT: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            state        <= S_WB;
          end
        end
        S_WB: begin
          if (f_we && (f_ws != 2'b11) && (f_a3 != 5'd0)) begin
            regs[f_a3] <= wb_data;
          end
          if (f_j || (f_b && flag)) begin
            pc <= pc + pc_off;
          end else begin
            pc <= pc + PC_W'(1);
          end
`ifdef MCCORE_PERF_CNT_EN
          instret <= instret + 32'd1;
`endif
          state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: expected display words are queued when a program is
// loaded and checked as each out_valid/out_ready transfer happens.
module tb_multicycle_core;
  localparam int DATA_W = 32;
  localparam int PC_W   = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [PC_W-1:0]   pc;
  logic [31:0]       imem_rdata = '0;
  logic              halted;
`ifdef MCCORE_PERF_CNT_EN
  logic [31:0]       instret;
`endif

  multicycle_core_if #(.DATA_W(DATA_W)) io ();

  multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .io         (io.master),
    .halted     (halted),
    .pc         (pc)
`ifdef MCCORE_PERF_CNT_EN
    ,
    .instret    (instret)
`endif
  );

  logic [31:0]       rom [256];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;
  int                pass_cnt = 0;
  int                total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  always @(negedge clk) begin
    if (reset_n && io.out_valid && io.out_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_unexpected: got out_data=0x%08h, expected no transfer", io.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (io.out_data !== mon_exp)
          $display("FAIL out_data: got 0x%08h, expected 0x%08h", io.out_data, mon_exp);
        else
          pass_cnt++;
      end
    end
  end

  function automatic logic [31:0] enc(input logic j, input logic b, input logic we,
                                      input logic [1:0] ws, input logic [3:0] op,
                                      input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [4:0] a3, input logic [7:0] c);
    return {j, b, we, ws, op, a1, a2, a3, c};
  endfunction

  task automatic begin_test();
    reset_n      = 1'b0;
    io.out_ready = 1'b1;
    io.sw_valid  = 1'b0;
    io.sw_data   = '0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) rom[i] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    begin_test();
    rom[0] = 32'h20000105;
    rom[1] = 32'h18040000;
    io.out_ready = 1'b0;
    total_cnt++;
    if ({pc, halted, io.out_valid, io.sw_ready, io.out_data} !== {8'h00, 1'b0, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_state: got pc=%0d halted=%b ov=%b sr=%b od=0x%08h, expected all 0",
               pc, halted, io.out_valid, io.sw_ready, io.out_data);
    else pass_cnt++;
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL reach_wait_out: got out_valid never, expected 1");
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({io.out_valid, pc, halted, io.out_data} !== {1'b0, 8'h00, 1'b0, 32'h0})
      $display("FAIL async_reset: got ov=%b pc=%0d halted=%b od=0x%08h, expected 0/0/0/0",
               io.out_valid, pc, halted, io.out_data);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total_cnt++;
    if (imem_addr !== 8'h00) $display("FAIL release_addr: got %0d, expected 0", imem_addr);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (pc !== 8'h00) $display("FAIL pc_before_wb: got %0d, expected 0", pc);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (pc !== 8'h01) $display("FAIL pc_after_first_wb: got %0d, expected 1", pc);
    else pass_cnt++;
  endtask

  task automatic test_const_out();
    bit ok;
    begin_test();
    rom[0] = 32'h20000105;
    rom[1] = 32'h18040000;
    rom[2] = 32'h80000000;
    exp_q.push_back(32'h00000005);
    release_reset();
    wait_halt(ok);
    total_cnt++;
    if (!(ok && pc === 8'd2)) $display("FAIL halt_pc: got halted=%b pc=%0d, expected 1/2", ok, pc);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({halted, pc, io.out_valid} !== {1'b1, 8'd2, 1'b0})
      $display("FAIL halt_stable: got halted=%b pc=%0d ov=%b, expected 1/2/0", halted, pc, io.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL const_out_drain: got %0d pending, expected 0", exp_q.size());
    else pass_cnt++;
`ifdef MCCORE_PERF_CNT_EN
    total_cnt++;
    if (instret !== 32'd2) $display("FAIL instret_const: got %0d, expected 2", instret);
    else pass_cnt++;
`endif
  endtask

  task automatic test_sign_ext();
    bit ok;
    begin_test();
    rom[0] = 32'h200001FF;
    rom[1] = 32'h18040000;
    rom[2] = 32'h80000000;
    exp_q.push_back(32'hFFFFFFFF);
    release_reset();
    wait_halt(ok);
    total_cnt++;
    if (!(ok && exp_q.size() == 0))
      $display("FAIL sign_ext_done: got halted=%b pending=%0d, expected 1/0", ok, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_alu();
    bit ok;
    logic [31:0] alu_exp [16] = '{32'h00000001, 32'hFFFFFFF9, 32'h00000004, 32'hFFFFFFFD,
                                  32'hFFFFFFF9, 32'hFFFFFFD0, 32'h0FFFFFFF, 32'hFFFFFFFF,
                                  32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};
    begin_test();
    rom[0] = 32'h20000105;
    rom[1] = 32'h20000207;
    rom[2] = 32'h30044300;
    rom[3] = enc(1'b0, 1'b0, 1'b0, 2'b11, 4'h0, 5'd3, 5'd0, 5'd0, 8'h00);
    exp_q.push_back(32'h0000000C);
    rom[4] = enc(1'b0, 1'b0, 1'b1, 2'b00, 4'h0, 5'd0, 5'd0, 5'd1, 8'hFD);
    rom[5] = enc(1'b0, 1'b0, 1'b1, 2'b00, 4'h0, 5'd0, 5'd0, 5'd2, 8'h04);
    for (int i = 0; i < 16; i++) begin
      rom[6 + 2 * i] = enc(1'b0, 1'b0, 1'b1, 2'b10, 4'(i), 5'd1, 5'd2, 5'd3, 8'h00);
      rom[7 + 2 * i] = enc(1'b0, 1'b0, 1'b0, 2'b11, 4'h0, 5'd3, 5'd0, 5'd0, 8'h00);
      exp_q.push_back(alu_exp[i]);
    end
    rom[38] = 32'h80000000;
    release_reset();
    wait_halt(ok);
    total_cnt++;
    if (!(ok && exp_q.size() == 0 && pc === 8'd38))
      $display("FAIL alu_done: got halted=%b pending=%0d pc=%0d, expected 1/0/38", ok, exp_q.size(), pc);
    else pass_cnt++;
  endtask

  task automatic test_sw_in();
    bit ok;
    bit seen;
    begin_test();
    rom[0] = 32'h28000100;
    rom[1] = 32'h18040000;
    rom[2] = 32'h80000000;
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io.sw_ready) begin
        seen = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL sw_ready_rise: got sw_ready never, expected 1");
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({io.sw_ready, pc} !== {1'b1, 8'd0})
        $display("FAIL sw_stall: got sw_ready=%b pc=%0d, expected 1/0", io.sw_ready, pc);
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    io.sw_data  = 32'h000000A5;
    io.sw_valid = 1'b1;
    exp_q.push_back(32'h000000A5);
    @(posedge clk);
    #1;
    io.sw_valid = 1'b0;
    io.sw_data  = 32'hDEADBEEF;
    wait_halt(ok);
    total_cnt++;
    if (!(ok && exp_q.size() == 0 && io.sw_ready === 1'b0))
      $display("FAIL sw_in_done: got halted=%b pending=%0d sw_ready=%b, expected 1/0/0",
               ok, exp_q.size(), io.sw_ready);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    bit seen;
    begin_test();
    rom[0] = 32'h20000101;
    rom[4] = enc(1'b0, 1'b1, 1'b0, 2'b00, 4'h9, 5'd1, 5'd1, 5'd0, 8'hF0);
    rom[5] = 32'h440420FE;
    release_reset();
    for (int loop = 0; loop < 2; loop++) begin
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (pc == 8'd5) begin
          seen = 1'b1;
          break;
        end
      end
      for (int i = 0; i < 20 && seen; i++) begin
        @(negedge clk);
        if (pc != 8'd5) break;
      end
      total_cnt++;
      if (!(seen && pc === 8'd3 && halted === 1'b0))
        $display("FAIL branch_taken: got reached5=%b pc=%0d halted=%b, expected 1/3/0", seen, pc, halted);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_stall();
    bit ok;
    bit seen;
    begin_test();
    rom[0]   = 32'h800000FF;
    rom[255] = enc(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 8'h02);
    rom[1]   = 32'h2000015A;
    rom[2]   = 32'h18040000;
    rom[3]   = 32'h80000000;
    io.out_ready = 1'b0;
    release_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pc != 8'd0) break;
    end
    total_cnt++;
    if (pc !== 8'hFF) $display("FAIL wrap_back: got pc=0x%02h, expected 0xff", pc);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pc != 8'hFF) break;
    end
    total_cnt++;
    if (pc !== 8'h01) $display("FAIL wrap_fwd: got pc=0x%02h, expected 0x01", pc);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL stall_valid: got out_valid never, expected 1");
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({io.out_valid, io.out_data} !== {1'b1, 32'h0000005A})
        $display("FAIL out_stall: got ov=%b od=0x%08h, expected 1/0x0000005a", io.out_valid, io.out_data);
      else pass_cnt++;
    end
    exp_q.push_back(32'h0000005A);
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    wait_halt(ok);
    total_cnt++;
    if (!(ok && pc === 8'd3 && exp_q.size() == 0))
      $display("FAIL wrap_done: got halted=%b pc=%0d pending=%0d, expected 1/3/0", ok, pc, exp_q.size());
    else pass_cnt++;
`ifdef MCCORE_PERF_CNT_EN
    total_cnt++;
    if (instret !== 32'd4) $display("FAIL instret_wrap: got %0d, expected 4", instret);
    else pass_cnt++;
`endif
  endtask

  initial begin
    io.sw_data   = '0;
    io.sw_valid  = 1'b0;
    io.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_const_out();
    test_sign_ext();
    test_alu();
    test_sw_in();
    test_branch();
    test_wrap_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
